// File: rtl/sigmoid_pkg.sv
// Shared types and widths for the sigmoid arbiter and its round-robin picker.
package sigmoid_pkg;

    localparam int ARGUMENT_W  = 16;
    localparam int RESULT_W    = 8;
    localparam int ERROR_W     = 16;
    localparam int PROPAGATE_W = 16;

    // One transaction walks IDLE -> FORWARD -> RESULT [-> ERROR -> PROPAGATE] -> IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FORWARD   = 3'd1,
        RESULT    = 3'd2,
        ERROR     = 3'd3,
        PROPAGATE = 3'd4
    } state_t;

endpackage

// File: rtl/sigmoid_arbiter_round_robin.sv
// Combinational N-way round-robin picker: the first active request found
// scanning circularly upward from pointer wins.
module round_robin #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] idx;
    logic          found;

    // Circular scan from pointer; later candidates are ignored once one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(pointer) + i) % N);
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one sigmoid unit among N requesters. A requester owns the unit for a
// whole forward pass (argument, result) and, when train was high at grant, the
// following backward pass (error, propagate).
// Handshake: every channel transfers on a cycle where valid and ready are both
// high; a valid, once raised, holds with stable data until that transfer.
// Optional feature: define SIGMOID_ARBITER_TIMEOUT_EN to abandon a backward
// pass whose error does not arrive within TIMEOUT cycles of entering ERROR.
module sigmoid_arbiter
    import sigmoid_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            train,
    input  logic [N-1:0]                    req_argument_valid,
    output logic [N-1:0]                    req_argument_ready,
    input  logic [N-1:0][ARGUMENT_W-1:0]    req_argument_data,
    output logic [N-1:0]                    req_result_valid,
    input  logic [N-1:0]                    req_result_ready,
    output logic [N-1:0][RESULT_W-1:0]      req_result_data,
    input  logic [N-1:0]                    req_error_valid,
    output logic [N-1:0]                    req_error_ready,
    input  logic [N-1:0][ERROR_W-1:0]       req_error_data,
    output logic [N-1:0]                    req_propagate_valid,
    input  logic [N-1:0]                    req_propagate_ready,
    output logic [N-1:0][PROPAGATE_W-1:0]   req_propagate_data,
    output logic                            argument_valid,
    input  logic                            argument_ready,
    output logic [ARGUMENT_W-1:0]           argument_data,
    input  logic                            result_valid,
    output logic                            result_ready,
    input  logic [RESULT_W-1:0]             result_data,
    output logic                            error_valid,
    input  logic                            error_ready,
    output logic [ERROR_W-1:0]              error_data,
    input  logic                            propagate_valid,
    output logic                            propagate_ready,
    input  logic [PROPAGATE_W-1:0]          propagate_data,
    output logic [N-1:0]                    grant,
    output logic                            timeout,
    output state_t                          state,
    output logic [IW-1:0]                   ptr
);

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_q, win_d;
    logic          train_q, train_d;
    logic          release_txn;
    logic [N-1:0]  rr_grant;
    logic [IW-1:0] rr_idx;

    round_robin #(.N(N), .IW(IW)) u_round_robin (
        .request   (req_argument_valid),
        .pointer   (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

`ifdef SIGMOID_ARBITER_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        tmo_fire;
    logic        timeout_q;
`endif

    // State register plus the per-transaction owner, pointer and train latch.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            train_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            train_q <= train_d;
        end
    end

    // Next-state: advance on each owned channel's transfer, release at the end.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        train_d     = train_q;
        release_txn = 1'b0;
`ifdef SIGMOID_ARBITER_TIMEOUT_EN
        tmo_fire    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_argument_valid) begin
                    grant_d = rr_grant;
                    win_d   = rr_idx;
                    train_d = train;
                    state_d = FORWARD;
                end
            end
            FORWARD: begin
                if (req_argument_valid[win_q] && argument_ready) state_d = RESULT;
            end
            RESULT: begin
                if (result_valid && req_result_ready[win_q]) begin
                    if (train_q) state_d = ERROR;
                    else         release_txn = 1'b1;
                end
            end
            ERROR: begin
                if (req_error_valid[win_q] && error_ready) state_d = PROPAGATE;
`ifdef SIGMOID_ARBITER_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    release_txn = 1'b1;
                    tmo_fire    = 1'b1;
                end
`endif
            end
            PROPAGATE: begin
                if (propagate_valid && req_propagate_ready[win_q]) release_txn = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (release_txn) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
        end
    end

`ifdef SIGMOID_ARBITER_TIMEOUT_EN
    // Error-wait counter: restarts on ERROR entry, counts while waiting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_fire;
            if (state_q != ERROR) cnt_q <= '0;
            else                  cnt_q <= cnt_q + 16'd1;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Channel routing: only the owner's channel of the current phase is connected.
    always_comb begin
        argument_valid      = (state_q == FORWARD) && req_argument_valid[win_q];
        argument_data       = req_argument_data[win_q];
        req_argument_ready  = (state_q == FORWARD && argument_ready) ? grant_q : '0;
        result_ready        = (state_q == RESULT) && req_result_ready[win_q];
        req_result_valid    = (state_q == RESULT && result_valid) ? grant_q : '0;
        error_valid         = (state_q == ERROR) && req_error_valid[win_q];
        error_data          = req_error_data[win_q];
        req_error_ready     = (state_q == ERROR && error_ready) ? grant_q : '0;
        propagate_ready     = (state_q == PROPAGATE) && req_propagate_ready[win_q];
        req_propagate_valid = (state_q == PROPAGATE && propagate_valid) ? grant_q : '0;
        for (int i = 0; i < N; i++) begin
            req_result_data[i]    = result_data;
            req_propagate_data[i] = propagate_data;
        end
    end

    assign grant = grant_q;
    assign state = state_q;
    assign ptr   = ptr_q;

endmodule
